// File: rtl/main_memory_responder.sv
// main_memory_responder
//   Word-addressed backing store that answers the L2 cache memory port.
//   The access latency is fixed and set by a parameter, and only one request
//   is outstanding at a time. A request is accepted in IDLE, counted down in
//   BUSY, answered with a one-cycle mem_ready pulse in RESP, and then the FSM
//   waits in HOLD until the requester releases mem_read/mem_write.
//   Optional feature macro: MEM_STATS_EN adds saturating rd_count/wr_count
//   outputs. They count responses, whether the address is in range or not.
module main_memory_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_DEPTH     = 4096,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_ready,
    output logic                  mem_hit
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    localparam int OFS     = $clog2(DATA_WIDTH / 8);
    localparam int IDXW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNTW    = $clog2(MAX_LAT + 1);

    localparam logic [CNTW-1:0] RD_LOAD  = CNTW'(READ_LATENCY - 1);
    localparam logic [CNTW-1:0] WR_LOAD  = CNTW'(WRITE_LATENCY - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    logic [DATA_WIDTH-1:0] mem_array [MEM_DEPTH];

    logic [1:0]            state_r;
    logic [CNTW-1:0]       cnt_r;
    logic                  op_wr_r;
    logic                  in_range_r;
    logic [IDXW-1:0]       idx_r;
    logic [DATA_WIDTH-1:0] wdata_r;

    logic                  req_s;
    logic                  in_range_s;
    logic [IDXW-1:0]       idx_s;
    logic [CNTW-1:0]       load_s;
    logic                  busy_done_s;
    logic                  commit_wr_s;

    // Decode the request, the word index and the range check, and detect the end of BUSY.
    always_comb begin
        req_s       = mem_read | mem_write;
        idx_s       = mem_addr[OFS +: IDXW];
        in_range_s  = ((mem_addr >> (OFS + IDXW)) == {ADDR_WIDTH{1'b0}});
        busy_done_s = (state_r == ST_BUSY) && (cnt_r == CNT_ZERO);
        commit_wr_s = busy_done_s & op_wr_r & in_range_r;
        // If both request lines are high, the access is a write.
        if (mem_write) begin
            load_s = WR_LOAD;
        end else begin
            load_s = RD_LOAD;
        end
    end

    // Request FSM. It captures the request, counts down the latency and drives the registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            op_wr_r     <= 1'b0;
            in_range_r  <= 1'b0;
            idx_r       <= {IDXW{1'b0}};
            wdata_r     <= {DATA_WIDTH{1'b0}};
            mem_ready   <= 1'b0;
            mem_hit     <= 1'b0;
            mem_data_in <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mem_ready <= 1'b0;
                    mem_hit   <= 1'b0;
                    if (req_s) begin
                        op_wr_r    <= mem_write;
                        in_range_r <= in_range_s;
                        idx_r      <= idx_s;
                        wdata_r    <= mem_data_out;
                        cnt_r      <= load_s;
                        state_r    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r   <= ST_RESP;
                        mem_ready <= 1'b1;
                        mem_hit   <= in_range_r;
                        // A write response leaves the last read data unchanged.
                        if (!op_wr_r) begin
                            if (in_range_r) begin
                                mem_data_in <= mem_array[idx_r];
                            end else begin
                                mem_data_in <= {DATA_WIDTH{1'b0}};
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    mem_ready <= 1'b0;
                    mem_hit   <= 1'b0;
                    state_r   <= ST_HOLD;
                end
                ST_HOLD: begin
                    // A level request that is still high is not served a second time.
                    if (!req_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    mem_ready <= 1'b0;
                    mem_hit   <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array. It is not reset. A write commits on the edge that enters RESP,
    // so an access aborted by reset in BUSY is never stored.
    always_ff @(posedge clk) begin
        if (commit_wr_s) begin
            mem_array[idx_r] <= wdata_r;
        end
    end

`ifdef MEM_STATS_EN
    // Saturating counters of read and write responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (busy_done_s && !op_wr_r && (rd_count != 16'hFFFF)) begin
                rd_count <= rd_count + 16'd1;
            end
            if (busy_done_s && op_wr_r && (wr_count != 16'hFFFF)) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule
